// File: rtl/iic_arbiter_if.sv
// Bundle of requester-side and driver-side signals around the IIC EEPROM arbiter.
// The arbiter takes the slave view; the user controllers and the byte driver take the master view.
interface iic_arbiter_if;
    logic       req0_wr;
    logic       req0_rd;
    logic       req1_wr;
    logic       req1_rd;
    logic [7:0] req0_addr;
    logic [7:0] req1_addr;
    logic [7:0] req0_wdata;
    logic [7:0] req1_wdata;
    logic       req0_done;
    logic       req1_done;
    logic       req0_err;
    logic       req1_err;
    logic [7:0] rd_data;
    logic [1:0] grant;
    logic       busy;
    logic       wr_sig;
    logic       rd_sig;
    logic [7:0] addr_sig;
    logic [7:0] wr_data;
    logic       done_sig;
    logic [7:0] iic_rd_data;

    modport master (
        output req0_wr, req0_rd, req1_wr, req1_rd,
        output req0_addr, req1_addr, req0_wdata, req1_wdata,
        output done_sig, iic_rd_data,
        input  req0_done, req1_done, req0_err, req1_err,
        input  rd_data, grant, busy, wr_sig, rd_sig, addr_sig, wr_data
    );

    modport slave (
        input  req0_wr, req0_rd, req1_wr, req1_rd,
        input  req0_addr, req1_addr, req0_wdata, req1_wdata,
        input  done_sig, iic_rd_data,
        output req0_done, req1_done, req0_err, req1_err,
        output rd_data, grant, busy, wr_sig, rd_sig, addr_sig, wr_data
    );
endinterface

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one IIC EEPROM byte driver between two requesters,
// with a strobe-until-done handshake, per-owner done/timeout pulses and registered read data.
module iic_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned TCW            = 22
) (
    input  logic          clk_50M,
    input  logic          rst_n,
    iic_arbiter_if.slave  bus_io
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam logic [TCW-1:0] CNT_LAST = TCW'(TIMEOUT_CYCLES - 1);

    state_e         state_q, state_d;
    logic           last_q, last_d;      // 1: port 1 was served last
    logic [TCW-1:0] cnt_q, cnt_d;
    logic           wr_sig_q, wr_sig_d;
    logic           rd_sig_q, rd_sig_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic [1:0]     grant_q, grant_d;
    logic           busy_q, busy_d;
    logic           done0_q, done0_d;
    logic           done1_q, done1_d;
    logic           err0_q, err0_d;
    logic           err1_q, err1_d;

    logic req_any0, req_any1, pick1, pick_wr;
    logic start, finish_done, finish_err;

    assign req_any0 = bus_io.req0_wr | bus_io.req0_rd;
    assign req_any1 = bus_io.req1_wr | bus_io.req1_rd;
    // On a tie the port not served last wins.
    assign pick1    = req_any1 & (~req_any0 | ~last_q);
    assign pick_wr  = pick1 ? bus_io.req1_wr : bus_io.req0_wr;

    assign start       = (state_q == ST_IDLE) & (req_any0 | req_any1);
    // A done arriving on the final counter cycle wins over the timeout.
    assign finish_done = (state_q == ST_BUSY) & bus_io.done_sig;
    assign finish_err  = (state_q == ST_BUSY) & ~bus_io.done_sig & (cnt_q == CNT_LAST);

    // NOTE: reset is sampled on the clock edge only, so it lives inside the clocked branch.
    // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            wr_sig_q  <= 1'b0;
            rd_sig_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            wr_sig_q  <= wr_sig_d;
            rd_sig_q  <= rd_sig_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_BUSY;
            ST_BUSY:    if (finish_done || finish_err) state_d = ST_RELEASE;
            ST_RELEASE: if (!bus_io.done_sig) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: every output is given a hold/default value first so no path through the case infers a latch.
    always_comb begin
        last_d    = last_q;
        cnt_d     = cnt_q;
        wr_sig_d  = wr_sig_q;
        rd_sig_d  = rd_sig_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = pick1 ? bus_io.req1_addr  : bus_io.req0_addr;
                    wdata_d  = pick1 ? bus_io.req1_wdata : bus_io.req0_wdata;
                    wr_sig_d = pick_wr;
                    rd_sig_d = ~pick_wr;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    last_d   = pick1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + TCW'(1);
                if (finish_done || finish_err) begin
                    wr_sig_d = 1'b0;
                    rd_sig_d = 1'b0;
                    grant_d  = 2'b00;
                end
                if (finish_done) begin
                    done0_d = grant_q[0];
                    done1_d = grant_q[1];
                    if (rd_sig_q) rd_data_d = bus_io.iic_rd_data;
                end
                if (finish_err) begin
                    err0_d = grant_q[0];
                    err1_d = grant_q[1];
                end
            end
            ST_RELEASE: begin
                if (!bus_io.done_sig) busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus_io.req0_done = done0_q;
    assign bus_io.req1_done = done1_q;
    assign bus_io.req0_err  = err0_q;
    assign bus_io.req1_err  = err1_q;
    assign bus_io.rd_data   = rd_data_q;
    assign bus_io.grant     = grant_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.wr_sig    = wr_sig_q;
    assign bus_io.rd_sig    = rd_sig_q;
    assign bus_io.addr_sig  = addr_q;
    assign bus_io.wr_data   = wdata_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed and randomized bench for iic_arbiter: two requesters and a driver model,
// checked against a transaction-level model of the arbitration and handshake rules.
module tb_iic_arbiter;

    localparam int TIMEOUT = 16;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    always #10 clk_50M = ~clk_50M;

    iic_arbiter_if bus ();

    iic_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TCW(5)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus_io  (bus)
    );

    // Requester and driver stimulus
    logic [1:0] r_wr = '0;
    logic [1:0] r_rd = '0;
    logic [7:0] r_addr  [2];
    logic [7:0] r_wdata [2];
    logic       done_r = 1'b0;
    logic [7:0] rdb    = '0;

    assign bus.req0_wr     = r_wr[0];
    assign bus.req1_wr     = r_wr[1];
    assign bus.req0_rd     = r_rd[0];
    assign bus.req1_rd     = r_rd[1];
    assign bus.req0_addr   = r_addr[0];
    assign bus.req1_addr   = r_addr[1];
    assign bus.req0_wdata  = r_wdata[0];
    assign bus.req1_wdata  = r_wdata[1];
    assign bus.done_sig    = done_r;
    assign bus.iic_rd_data = rdb;

    // Transaction-level model state
    int         m_last = 1;
    logic [7:0] m_rd   = '0;
    logic [1:0] obs_grant;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    function automatic logic [3:0] pulses();
        return {bus.req1_err, bus.req0_err, bus.req1_done, bus.req0_done};
    endfunction

    // Driver model: done_sig high for cycles L..L+H-1 counted from the first strobe cycle (L=0: never).
    task automatic drive_done(input int c, input int L, input int H, input logic [7:0] rb);
        done_r = (L > 0) && (c >= L) && (c < L + H);
        rdb    = done_r ? rb : 8'($urandom);
    endtask

    // Called in an IDLE cycle with the requests for that cycle already set; returns in the next IDLE cycle.
    task automatic run_txn(input string name, input int L, input int H, input logic [7:0] rb);
        logic any0, any1, op_wr, tout;
        int win, dur, c, cnt, r, stray;
        logic [7:0] exp_addr, exp_wd;
        logic [3:0] exp_p;

        any0 = r_wr[0] | r_rd[0];
        any1 = r_wr[1] | r_rd[1];
        win  = (any0 && any1) ? (m_last == 1 ? 0 : 1) : (any0 ? 0 : 1);
        op_wr    = r_wr[win];
        tout     = (L == 0) || (L > TIMEOUT);
        dur      = tout ? TIMEOUT : L;
        exp_addr = r_addr[win];
        exp_wd   = r_wdata[win];
        m_last   = win;
        exp_p    = tout ? (win == 1 ? 4'b1000 : 4'b0100) : (win == 1 ? 4'b0010 : 4'b0001);

        tick();
        obs_grant = bus.grant;
        check({name, "_grant"}, {30'd0, bus.grant}, (win == 1) ? 2 : 1);
        check({name, "_start"}, {bus.busy, bus.wr_sig, bus.rd_sig}, {1'b1, op_wr, ~op_wr});
        check({name, "_addr_data"}, {bus.addr_sig, bus.wr_data}, {exp_addr, exp_wd});

        c = 1; cnt = 0; stray = 0;
        while (c <= TIMEOUT + 4 && (bus.wr_sig || bus.rd_sig)) begin
            cnt++;
            if (pulses() != 0) stray++;
            if (bus.addr_sig !== exp_addr || bus.grant !== obs_grant) stray++;
            drive_done(c, L, H, rb);
            tick();
            c++;
        end
        check({name, "_strobe_len"}, cnt, dur);
        check({name, "_pulse"}, {28'd0, pulses()}, {28'd0, exp_p});
        if (!tout && !op_wr) m_rd = rb;
        check({name, "_rel"}, {bus.rd_data, bus.grant, bus.busy}, {m_rd, 2'b00, 1'b1});

        r = dur + 1;
        while (L > 0 && r >= L && r < L + H) r++;

        drive_done(c, L, H, rb);
        tick();
        c++;
        if (op_wr) r_wr[win] = 1'b0;
        else       r_rd[win] = 1'b0;
        while (bus.busy === 1'b1 && c <= dur + H + 6) begin
            if (pulses() != 0) stray++;
            drive_done(c, L, H, rb);
            tick();
            c++;
        end
        if (pulses() != 0) stray++;
        done_r = 1'b0;
        check({name, "_idle_cycle"}, c, r + 1);
        check({name, "_stray"}, stray, 0);
        check({name, "_idle_hold"}, {bus.addr_sig, bus.wr_data, bus.rd_data, bus.grant},
              {exp_addr, exp_wd, m_rd, 2'b00});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {bus.grant, bus.busy, bus.wr_sig, bus.rd_sig, pulses()}, 0);
        check({name, "_data"}, {bus.addr_sig, bus.wr_data, bus.rd_data}, 0);
    endtask

    task automatic new_req(input int p);
        int sel;
        sel = $urandom_range(0, 3);
        r_wr[p]    = (sel <= 1) || (sel == 3);
        r_rd[p]    = (sel >= 2);
        r_addr[p]  = 8'($urandom);
        r_wdata[p] = 8'($urandom);
    endtask

    initial begin
        int L, H;
        r_addr[0] = '0; r_addr[1] = '0; r_wdata[0] = '0; r_wdata[1] = '0;

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single write from port 0
        r_wr[0] = 1'b1; r_addr[0] = 8'h00; r_wdata[0] = 8'hFF;
        run_txn("single_wr", 10, 1, 8'h00);

        // Single read from port 1
        r_rd[1] = 1'b1; r_addr[1] = 8'h00; r_wdata[1] = 8'h11;
        run_txn("single_rd", 6, 1, 8'hA5);
        check("rd_hold", {24'd0, bus.rd_data}, 32'hA5);

        // Timeout, then a normal transaction
        r_wr[0] = 1'b1; r_addr[0] = 8'h12; r_wdata[0] = 8'h34;
        run_txn("timeout", 0, 1, 8'h00);
        r_rd[0] = 1'b1; r_addr[0] = 8'h13;
        run_txn("after_to", 3, 1, 8'h5C);

        // Level done held 5 cycles
        r_wr[1] = 1'b1; r_addr[1] = 8'h40; r_wdata[1] = 8'h41;
        run_txn("level_done", 5, 5, 8'h00);

        // Done on the final counter cycle, and on the first strobe cycle
        r_rd[1] = 1'b1; r_addr[1] = 8'h7E;
        run_txn("done_at_limit", TIMEOUT, 1, 8'h3C);
        r_wr[0] = 1'b1; r_rd[0] = 1'b1; r_addr[0] = 8'h21; r_wdata[0] = 8'h99;
        run_txn("done_first", 1, 2, 8'h00);
        run_txn("pending_rd", 2, 1, 8'hE7);

        // Reset in cycle 4 of BUSY
        r_wr[0] = 1'b1; r_addr[0] = 8'h5A; r_wdata[0] = 8'hC3;
        repeat (4) tick();
        check("mid_busy", {bus.wr_sig, bus.grant}, 3'b101);
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_reset");
        r_wr = '0;
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");
        m_last = 1;
        m_rd   = '0;

        // Simultaneous requests with immediate re-request
        r_wr = 2'b11;
        r_addr[0] = 8'h01; r_wdata[0] = 8'hA0;
        r_addr[1] = 8'h02; r_wdata[1] = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            run_txn("simul", int'($urandom_range(2, 8)), 1, 8'h00);
            check("rr_order", {30'd0, obs_grant}, (i % 2 == 1) ? 2 : 1);
            r_wr[m_last]    = 1'b1;
            r_wdata[m_last] = 8'($urandom);
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++)
                if (!r_wr[p] && !r_rd[p] && $urandom_range(0, 2) != 0) new_req(p);
            if (r_wr == 2'b00 && r_rd == 2'b00) new_req(int'($urandom_range(0, 1)));
            L = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            H = int'($urandom_range(1, 4));
            run_txn("rand", L, H, 8'($urandom));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iic_arbiter.md
# iic_arbiter

Two-port arbiter sharing the single IIC EEPROM byte driver between two independent requesters, such as a boot-time parameter loader and a runtime logger. It accepts level-held write/read requests, grants the driver round-robin, and drives the driver's `wr_sig`/`rd_sig`/`addr_sig`/`wr_data` strobe-until-`done_sig` handshake. Each transaction returns a one-cycle `done` or timeout `err` pulse to its owner, and read data is registered for that owner. The block sits between the user controllers and the IIC driver, replacing the direct controller-to-driver connection.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000: cycles in BUSY without `done_sig` before abort (50 ms at 50 MHz).
- `TCW`, default 22: width of the timeout counter; must satisfy 2^TCW > TIMEOUT_CYCLES.
- `clk_50M` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req0_wr`, `req1_wr` in 1: write request, level, held until the matching done or err pulse.
- `req0_rd`, `req1_rd` in 1: read request, level, held until the matching done or err pulse.
- `req0_addr`, `req1_addr` in 8: EEPROM byte address.
- `req0_wdata`, `req1_wdata` in 8: write data.
- `req0_done`, `req1_done` out 1: one-cycle pulse, transaction complete.
- `req0_err`, `req1_err` out 1: one-cycle pulse, transaction aborted by timeout.
- `rd_data` out 8: last successfully read byte, registered.
- `grant` out 2: one-hot owner of the driver; 2'b00 when idle.
- `busy` out 1: high in BUSY and RELEASE.
- `wr_sig`, `rd_sig` out 1: driver strobes, registered, never high together.
- `addr_sig`, `wr_data` out 8: driver address and data, registered.
- `done_sig` in 1: driver completion; may be a pulse or a level.
- `iic_rd_data` in 8: driver read byte, valid while `done_sig` is high after a read.

## Operation
- The FSM has three states: IDLE, BUSY and RELEASE. All outputs are registered.
- IDLE:
  - Port n requests when `reqn_wr | reqn_rd`.
  - If only one port requests, it wins. If both request, the port not served last wins.
  - The `last` flag resets to 1, so port 0 wins the first tie.
  - On grant: latch the port's address and data into `addr_sig`/`wr_data`. Set `wr_sig` if `reqn_wr`, else set `rd_sig`. If a port asserts both, the write is performed; the read is left pending.
  - Also on grant: set `grant`, update `last`, clear the timeout counter and enter BUSY.
- BUSY:
  - Hold the strobe, address and data constant, and increment the counter.
  - On `done_sig` = 1: clear the strobe, pulse `reqn_done` and enter RELEASE. For a read, also load `rd_data` from `iic_rd_data`.
  - On counter = TIMEOUT_CYCLES-1 with no `done_sig`: clear the strobe, pulse `reqn_err`, leave `rd_data` unchanged and enter RELEASE.
  - Request inputs are ignored in BUSY; withdrawing a request does not abort the transaction.
- RELEASE:
  - Strobes stay low and `grant` is cleared on entry.
  - Return to IDLE on the first cycle with `done_sig` = 0. This guarantees the driver sees the strobe low before the next transaction.
- `addr_sig` and `wr_data` keep their last values when idle.
- Reset (synchronous, any state) clears, on the next edge:
  - `wr_sig`, `rd_sig`, `addr_sig`, `wr_data`, `rd_data`, `grant`, `busy`, and every done/err output, all to 0;
  - `last` to 1, and the state to IDLE.
- Reset mid-transaction produces no done or err pulse.

## Timing
- Request high in IDLE cycle t: strobe, `grant` and `busy` are high in cycle t+1.
- `done_sig` first high in BUSY cycle k:
  - in cycle k+1: strobe low, `reqn_done` = 1, `rd_data` updated, state RELEASE;
  - in cycle k+2: `reqn_done` = 0, and the state is IDLE if `done_sig` was low in k+1.
- A requester clears its request in the cycle after it sees done, so the stale request is already low when IDLE samples.
- Minimum back-to-back spacing is 3 cycles: strobe drops at k+1, IDLE at k+2, next strobe at k+3.
- Timeout: strobe high for exactly TIMEOUT_CYCLES cycles, then `err` pulses for 1 cycle.
- A `done_sig` arriving in the same cycle the counter hits its limit counts as done, not err.
- Exactly one done-or-err pulse is produced per granted transaction.

## Test plan
- **Single write:** port 0 writes addr 0x00, data 0xFF; model driver raises `done_sig` 10 cycles after the strobe -> `addr_sig` = 0x00, `wr_data` = 0xFF, `wr_sig` high for 10 cycles, one `req0_done` pulse, `req1_*` quiet.
- **Single read:** port 1 reads addr 0x00; driver returns 0xA5 -> `rd_sig` high, `rd_data` = 0xA5 in the `req1_done` cycle, held afterwards.
- **Simultaneous requests:** both ports request from reset, each re-requesting immediately after its done, 4 times -> grant order 0,1,0,1, with at least 3 cycles between strobes.
- **Timeout:** TIMEOUT_CYCLES = 16, driver never responds -> `wr_sig` high exactly 16 cycles, then `req0_err` pulse; the next request is served normally.
- **Level done:** driver holds `done_sig` for 5 cycles -> the block stays in RELEASE until `done_sig` falls, with no duplicate done pulse.
- **Reset mid-transfer:** `rst_n` low in cycle 4 of BUSY -> all outputs 0 on the next edge with no done/err; after reset, port 0 wins a tie.
